// File: rtl/regdump_ctrl_pkg.sv
// Shared definitions for the register-monitor dump sequencer and the
// monitor transmitter side: FSM state encodings, default header byte and
// counter widths.
package regdump_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_LATCH = 3'd2,
      ST_SEND  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] HDR_BYTE_DFLT = 8'hA5;

   // Register index width (32 architectural registers).
   localparam int IDX_W  = 5;

   // Byte counter within one 32-bit word (4 bytes).
   localparam int BCNT_W = 2;
   localparam logic [BCNT_W-1:0] BCNT_LAST = '1;

endpackage

// File: rtl/regdump_ctrl.sv
// Register-monitor dump sequencer.
// On a start pulse, walks the regfile debug port from r0 to r[LAST_REG],
// snapshots each 32-bit word and streams it MSB byte first over a
// valid/ready byte link, optionally preceded by a header byte.
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset_n   synchronous active-low reset
//   start     dump request, only honoured in IDLE
//   busy      high whenever the sequencer is not IDLE
//   done      one-cycle pulse after the final byte is accepted
//   dbg_ra    registered regfile debug read address
//   dbg_rd    combinational regfile debug read data
//   tx_data   byte to the monitor transmitter
//   tx_valid  tx_data is valid
//   tx_ready  transmitter accepts when tx_valid && tx_ready at the clock edge
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// HDR    | presenting the header byte
// LATCH  | snapshot dbg_rd for register idx (dbg_ra already == idx)
// SEND   | presenting shreg[31:24], four bytes per word
// DONE   | single-cycle completion pulse
module regdump_ctrl
   import regdump_ctrl_pkg::*;
#(
   parameter int unsigned LAST_REG = 31,
   parameter bit          HDR_EN   = 1'b1,
   parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DFLT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] dbg_ra,
   input  logic [31:0]      dbg_rd,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_REG);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       shreg;
   logic [BCNT_W-1:0] bcnt;

   // tx_data/tx_valid are registered alongside the state so they always equal
   // the decode of (state, shreg): HDR -> HDR_BYTE, SEND -> shreg[31:24].
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         dbg_ra   <= '0;
         shreg    <= '0;
         bcnt     <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx    <= '0;
                  dbg_ra <= '0;
                  busy   <= 1'b1;
                  if (HDR_EN) begin
                     state    <= ST_HDR;
                     tx_valid <= 1'b1;
                     tx_data  <= HDR_BYTE;
                  end else begin
                     state <= ST_LATCH;
                  end
               end
            end

            ST_HDR: begin
               if (tx_ready) begin
                  state    <= ST_LATCH;
                  tx_valid <= 1'b0;
                  tx_data  <= '0;
               end
            end

            ST_LATCH: begin
               // All four bytes of the word come from this single sample.
               shreg    <= dbg_rd;
               bcnt     <= '0;
               state    <= ST_SEND;
               tx_valid <= 1'b1;
               tx_data  <= dbg_rd[31:24];
            end

            ST_SEND: begin
               if (tx_ready) begin
                  shreg   <= shreg << 8;
                  bcnt    <= bcnt + 1'b1;
                  tx_data <= shreg[23:16];
                  if (bcnt == BCNT_LAST) begin
                     tx_valid <= 1'b0;
                     tx_data  <= '0;
                     // Terminal compare before increment keeps idx from
                     // wrapping when LAST_REG is 31.
                     if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        idx    <= idx + 1'b1;
                        dbg_ra <= idx + 1'b1;
                        state  <= ST_LATCH;
                     end
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               tx_valid <= 1'b0;
               tx_data  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regdump_ctrl.sv
// Bench for regdump_ctrl: main instance with header and 32 registers,
// second instance with no header and a single register.
module tb_regdump_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, tx_ready, busy, done, tx_valid;
   logic [4:0]  dbg_ra;
   logic [31:0] dbg_rd;
   logic [7:0]  tx_data;

   logic        start_b, tx_ready_b, busy_b, done_b, tx_valid_b;
   logic [4:0]  dbg_ra_b;
   logic [31:0] dbg_rd_b;
   logic [7:0]  tx_data_b;

   logic [31:0] rf [32];
   assign dbg_rd   = rf[dbg_ra];
   assign dbg_rd_b = rf[dbg_ra_b];

   regdump_ctrl #(.LAST_REG(31), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready)
   );

   regdump_ctrl #(.LAST_REG(0), .HDR_EN(1'b0), .HDR_BYTE(8'hA5)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
      .dbg_ra(dbg_ra_b), .dbg_rd(dbg_rd_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_err = 0;
   int n_chk = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] exp_word(input int i);
      return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h0101;
   endfunction

   // ---------------- behavioural model of the main instance ----------------
   // A dump is a byte list: header then each register word MSB first.
   // busy from the cycle after an accepted start until the cycle after the
   // final byte's acceptance (the done cycle) inclusive.
   bit          armed = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   logic [7:0]  expq [$];
   logic [7:0]  got  [$];
   int          n_done = 0;
   int          n_stall = 0;
   int          start_cyc = 0;
   int          done_spec = 0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h0;
   bit          acc;

   function automatic void load_stream();
      logic [31:0] w;
      expq.delete();
      expq.push_back(8'hA5);
      for (int i = 0; i < 32; i++) begin
         w = exp_word(i);
         expq.push_back(w[31:24]);
         expq.push_back(w[23:16]);
         expq.push_back(w[15:8]);
         expq.push_back(w[7:0]);
      end
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         if (!m_busy) chk("idle_valid", 32'(tx_valid), 32'd0);
         if (prev_stall) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
         end
         acc = reset_n && tx_valid && tx_ready;
         if (done && reset_n) begin
            n_done++;
            done_spec = cyc - start_cyc + 1;
         end
         if (acc) begin
            if (expq.size() == 0) begin
               chk("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               chk("byte", 32'(tx_data), 32'(expq.pop_front()));
            end
            got.push_back(tx_data);
         end
         if (reset_n && tx_valid && !tx_ready) n_stall++;
         prev_stall = reset_n && tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            expq.delete();
         end else if (m_done) begin
            m_busy = 1'b0;
            m_done = 1'b0;
         end else if (!m_busy && start) begin
            m_busy = 1'b1;
            load_stream();
            start_cyc = cyc + 1;
         end else if (m_busy && acc && expq.size() == 0) begin
            m_done = 1'b1;
         end
      end
   end

   // mode 0: ready=1; 1: random ready; 2: start re-pulsed in SEND and DONE;
   // 3: reset asserted in SEND of r7; 4: r5 changed the cycle after its LATCH.
   task automatic run(input int mode, input int budget);
      int k, d0;
      bit hit;
      k = 0; hit = 1'b0; d0 = n_done;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (n_done == d0 && k < budget && !(mode == 3 && hit)) begin
         @(posedge clk); #1;
         k++;
         start = 1'b0;
         case (mode)
            1: tx_ready = 1'($urandom_range(0, 1));
            2: if (done || k == 50) start = 1'b1;
            3: if (!hit && dbg_ra == 5'd7 && tx_valid) begin hit = 1'b1; reset_n = 1'b0; end
            4: if (!hit && dbg_ra == 5'd5 && tx_valid) begin hit = 1'b1; rf[5] = 32'hDEAD_BEEF; end
            default: ;
         endcase
      end
      if (mode != 3) begin
         if (n_done == d0) chk("timeout", 32'(k), 32'(budget + 1));
         @(posedge clk); #1;
         start = 1'b0;
         tx_ready = 1'b1;
         repeat (3) @(posedge clk);
         #1;
      end else if (!hit) begin
         chk("t4_reached_r7", 32'(hit), 32'd1);
      end
   endtask

   initial begin
      logic [7:0]  lit1 [9];
      logic [7:0]  bytes_b [$];
      logic [31:0] w5;
      int b_got, b_done, b_stall, sc, nd_b, dcyc_b;

      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  lit1 [9];
      logic [7:0]  bytes_b [$];
      logic [31:0] w5;
      int b_got, b_done, b_stall, sc, nd_b, dcyc_b;

      lit1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 8'h01};
      for (int i = 0; i < 32; i++) rf[i] = exp_word(i);
      reset_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
      start_b = 1'b0; tx_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      armed = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_ra", 32'(dbg_ra), 32'd0);
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: ready held high
      b_got = got.size(); b_done = n_done;
      run(0, 400);
      for (int i = 0; i < 9; i++) chk("t1_byte_lit", 32'(got[b_got + i]), 32'(lit1[i]));
      chk("t1_count", 32'(got.size() - b_got), 32'd129);
      chk("t1_done_cyc", 32'(done_spec), 32'd162);
      chk("t1_done_pulses", 32'(n_done - b_done), 32'd1);

      // 2: random backpressure
      b_got = got.size(); b_done = n_done; b_stall = n_stall;
      run(1, 2000);
      chk("t2_count", 32'(got.size() - b_got), 32'd129);
      chk("t2_done_cyc", 32'(done_spec), 32'(162 + n_stall - b_stall));
      chk("t2_stalls_seen", 32'(n_stall > b_stall), 32'd1);
      chk("t2_done_pulses", 32'(n_done - b_done), 32'd1);

      // 3: start while busy
      b_got = got.size(); b_done = n_done;
      run(2, 400);
      chk("t3_count", 32'(got.size() - b_got), 32'd129);
      chk("t3_done_cyc", 32'(done_spec), 32'd162);
      chk("t3_done_pulses", 32'(n_done - b_done), 32'd1);
      chk("t3_idle_after", 32'(busy), 32'd0);

      // 4: reset in SEND of r7, then a fresh dump
      b_got = got.size();
      run(3, 400);
      @(posedge clk); #1;
      chk("t4_valid", 32'(tx_valid), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_ra", 32'(dbg_ra), 32'd0);
      chk("t4_partial_count", 32'(got.size() - b_got), 32'd29);
      reset_n = 1'b1;
      @(posedge clk); #1;
      b_got = got.size(); b_done = n_done;
      run(0, 400);
      chk("t4_hdr", 32'(got[b_got]), 32'hA5);
      chk("t4_count", 32'(got.size() - b_got), 32'd129);
      chk("t4_done_cyc", 32'(done_spec), 32'd162);

      // 6: r5 modified after its snapshot
      b_got = got.size();
      run(4, 400);
      rf[5] = exp_word(5);
      w5 = {got[b_got + 21], got[b_got + 22], got[b_got + 23], got[b_got + 24]};
      chk("t6_r5_snapshot", w5, 32'h1000_0505);
      chk("t6_count", 32'(got.size() - b_got), 32'd129);

      // 5: no header, single register
      nd_b = 0; dcyc_b = 0;
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      sc = cyc;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (tx_valid_b && tx_ready_b) bytes_b.push_back(tx_data_b);
         if (done_b) begin
            nd_b++;
            dcyc_b = cyc - sc + 1;
         end
      end
      chk("t5_count", 32'(bytes_b.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("t5_byte", 32'(bytes_b[i]), 32'd0);
      chk("t5_done_cyc", 32'(dcyc_b), 32'd6);
      chk("t5_done_pulses", 32'(nd_b), 32'd1);
      chk("t5_idle_after", 32'(busy_b), 32'd0);

      chk("final_queue_empty", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
